// File: rtl/cpu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_ctrl_pkg
//  Purpose  : Shared encodings for the Mini SRC hardwired control unit:
//             opcodes, bus-source codes, ALU operation codes, the phase
//             enum, the step-counter type and the control-word bundle.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package cpu_ctrl_pkg;

    localparam int STEP_W = 3;
    typedef logic [STEP_W-1:0] step_t;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        HALT  = 2'd2
    } phase_t;

    // Opcodes (IR[31:27])
    localparam logic [4:0] OP_LD   = 5'd0,  OP_LDI  = 5'd1,  OP_ST   = 5'd2;
    localparam logic [4:0] OP_ADD  = 5'd3,  OP_SUB  = 5'd4,  OP_AND  = 5'd5;
    localparam logic [4:0] OP_OR   = 5'd6,  OP_ROR  = 5'd7,  OP_ROL  = 5'd8;
    localparam logic [4:0] OP_SHR  = 5'd9,  OP_SHRA = 5'd10, OP_SHL  = 5'd11;
    localparam logic [4:0] OP_ADDI = 5'd12, OP_ANDI = 5'd13, OP_ORI  = 5'd14;
    localparam logic [4:0] OP_DIV  = 5'd15, OP_MUL  = 5'd16, OP_NEG  = 5'd17;
    localparam logic [4:0] OP_NOT  = 5'd18, OP_BR   = 5'd19, OP_JR   = 5'd20;
    localparam logic [4:0] OP_JAL  = 5'd21, OP_IN   = 5'd22, OP_OUT  = 5'd23;
    localparam logic [4:0] OP_MFHI = 5'd24, OP_MFLO = 5'd25, OP_NOP  = 5'd26;
    localparam logic [4:0] OP_HALT = 5'd27;

    // Bus sources; 0..15 are the general registers
    localparam logic [4:0] BUS_HI  = 5'd16, BUS_LO  = 5'd17, BUS_ZHI = 5'd18;
    localparam logic [4:0] BUS_ZLO = 5'd19, BUS_PC  = 5'd20, BUS_MDR = 5'd21;
    localparam logic [4:0] BUS_INP = 5'd22, BUS_IMM = 5'd23;

    // ALU operations
    localparam logic [3:0] ALU_ADD = 4'd0,  ALU_SUB = 4'd1,  ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3,  ALU_ROR = 4'd4,  ALU_ROL = 4'd5;
    localparam logic [3:0] ALU_SHR = 4'd6,  ALU_SHRA = 4'd7, ALU_SHL = 4'd8;
    localparam logic [3:0] ALU_MUL = 4'd9,  ALU_DIV = 4'd10, ALU_NEG = 4'd11;
    localparam logic [3:0] ALU_NOT = 4'd12;

    // One cycle's worth of datapath controls
    typedef struct packed {
        logic       e_pc, e_ir, e_y, e_z, e_hi, e_lo, e_mdr, e_mar;
        logic       e_outport, e_inport, e_ra, e_con_ff, inc_pc;
        logic       ram_read, ram_write, mdr_read;
        logic       gra, grb, grc, e_rin, e_rout, ba_out, imm_sel;
        logic [4:0] bus;
        logic [3:0] alu_op;
    } ctrl_t;

    // Reserved opcodes behave as nop
    function automatic logic is_nop(input logic [4:0] op);
        return (op == OP_NOP) || (op > OP_HALT);
    endfunction

    function automatic logic [3:0] alu_code(input logic [4:0] op);
        logic [3:0] code;
        case (op)
            OP_SUB:          code = ALU_SUB;
            OP_AND, OP_ANDI: code = ALU_AND;
            OP_OR,  OP_ORI:  code = ALU_OR;
            OP_ROR:          code = ALU_ROR;
            OP_ROL:          code = ALU_ROL;
            OP_SHR:          code = ALU_SHR;
            OP_SHRA:         code = ALU_SHRA;
            OP_SHL:          code = ALU_SHL;
            OP_MUL:          code = ALU_MUL;
            OP_DIV:          code = ALU_DIV;
            OP_NEG:          code = ALU_NEG;
            OP_NOT:          code = ALU_NOT;
            default:         code = ALU_ADD;
        endcase
        return code;
    endfunction

    // Final execute step of each instruction
    function automatic step_t last_step(input logic [4:0] op);
        step_t s;
        case (op)
            OP_LD, OP_BR:                      s = 3'd7;
            OP_ST, OP_MUL, OP_DIV:             s = 3'd6;
            OP_LDI, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL,
            OP_SHR, OP_SHRA, OP_SHL, OP_ADDI, OP_ANDI, OP_ORI:
                                               s = 3'd5;
            OP_NEG, OP_NOT, OP_JAL, OP_IN:     s = 3'd4;
            default:                           s = 3'd3;
        endcase
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/control_unit.sv
`default_nettype none
// ============================================================================
//  Module   : control_unit
//  Purpose  : Hardwired Mini SRC control unit. A phase register plus a 3-bit
//             step counter sequence fetch (T0-T2) and execute (T3..T7);
//             every datapath control decodes combinationally from the
//             registered phase/step and the instruction register.
//  Ports    : clock, clear (async, active-high), IRout[31:0], CON, stop
//             -> register enables, memory strobes, register-select lines,
//             BusDataSelect[4:0], ALU_op[3:0], run
//  Revision : 1.0 - initial release
// ============================================================================
module control_unit
    import cpu_ctrl_pkg::*;
(
    input  logic        clock,
    input  logic        clear,
    input  logic [31:0] IRout,
    input  logic        CON,
    input  logic        stop,
    output logic        e_PC, e_IR, e_Y, e_Z, e_HI, e_LO, e_MDR, e_MAR,
    output logic        e_OutPort, e_InPort, e_RA, e_CON_FF, incPC,
    output logic        ram_read, ram_write, MDR_read,
    output logic        Gra, Grb, Grc, e_Rin, e_Rout, BAout, imm_sel,
    output logic [4:0]  BusDataSelect,
    output logic [3:0]  ALU_op,
    output logic        run
);

    phase_t     r_phase, w_phase_nxt;
    step_t      r_step,  w_step_nxt;
    ctrl_t      w_ctrl,  w_out;
    logic       w_run;

    logic [4:0] w_op;
    logic [4:0] w_bus_ra, w_bus_rb, w_bus_rc;
    logic       w_nop_t3, w_at_t0, w_imm_form;
    logic       w_unused_ir;

    assign w_op       = IRout[31:27];
    assign w_bus_ra   = {1'b0, IRout[26:23]};
    assign w_bus_rb   = {1'b0, IRout[22:19]};
    assign w_bus_rc   = {1'b0, IRout[18:15]};
    assign w_unused_ir = ^IRout[14:0];
    assign w_imm_form = (w_op == OP_ADDI) || (w_op == OP_ANDI) || (w_op == OP_ORI);

    // A nop has no execute work, so its T3 slot doubles as the next
    // instruction's T0; that keeps nop at three cycles.
    assign w_nop_t3 = (r_phase == EXEC) && (r_step == 3'd3) && is_nop(w_op);
    assign w_at_t0  = ((r_phase == FETCH) && (r_step == 3'd0)) || w_nop_t3;

    // ------------------------------------------------------------------
    // Phase / step register
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            r_phase <= FETCH;
            r_step  <= 3'd0;
        end else begin
            r_phase <= w_phase_nxt;
            r_step  <= w_step_nxt;
        end
    end

    always_comb begin
        w_phase_nxt = r_phase;
        w_step_nxt  = r_step;
        if (w_at_t0) begin
            // stop is only honoured here; holding lands on a true T0
            w_phase_nxt = FETCH;
            w_step_nxt  = stop ? 3'd0 : 3'd1;
        end else begin
            case (r_phase)
                FETCH: begin
                    if (r_step == 3'd2) w_phase_nxt = EXEC;
                    w_step_nxt = r_step + 3'd1;
                end
                EXEC: begin
                    if ((w_op == OP_HALT) && (r_step == 3'd3)) begin
                        w_phase_nxt = HALT;
                        w_step_nxt  = 3'd0;
                    end else if ((r_step == last_step(w_op)) || (r_step == 3'd7)) begin
                        w_phase_nxt = FETCH;
                        w_step_nxt  = 3'd0;
                    end else begin
                        w_step_nxt  = r_step + 3'd1;
                    end
                end
                HALT:    ;
                default: begin
                    w_phase_nxt = FETCH;
                    w_step_nxt  = 3'd0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output decode
    // ------------------------------------------------------------------
    always_comb begin
        w_ctrl = '0;
        w_run  = 1'b1;
        if (r_phase == HALT) begin
            w_run = 1'b0;
        end else if (w_at_t0) begin
            if (stop) begin
                w_run = 1'b0;
            end else begin
                w_ctrl.bus    = BUS_PC;
                w_ctrl.e_mar  = 1'b1;
                w_ctrl.inc_pc = 1'b1;
            end
        end else if (r_phase == FETCH) begin
            case (r_step)
                3'd1: begin
                    w_ctrl.ram_read = 1'b1;
                    w_ctrl.mdr_read = 1'b1;
                    w_ctrl.e_mdr    = 1'b1;
                end
                3'd2: begin
                    w_ctrl.bus  = BUS_MDR;
                    w_ctrl.e_ir = 1'b1;
                end
                default: ;
            endcase
        end else begin
            case (w_op)
                OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL, OP_SHR,
                OP_SHRA, OP_SHL, OP_ADDI, OP_ANDI, OP_ORI: begin
                    case (r_step)
                        3'd3: begin
                            w_ctrl.grb = 1'b1; w_ctrl.e_rout = 1'b1;
                            w_ctrl.bus = w_bus_rb; w_ctrl.e_y = 1'b1;
                        end
                        3'd4: begin
                            if (w_imm_form) begin
                                w_ctrl.bus = BUS_IMM; w_ctrl.imm_sel = 1'b1;
                            end else begin
                                w_ctrl.grc = 1'b1; w_ctrl.e_rout = 1'b1;
                                w_ctrl.bus = w_bus_rc;
                            end
                            w_ctrl.alu_op = alu_code(w_op);
                            w_ctrl.e_z    = 1'b1;
                        end
                        3'd5: begin
                            w_ctrl.bus = BUS_ZLO; w_ctrl.gra = 1'b1; w_ctrl.e_rin = 1'b1;
                        end
                        default: ;
                    endcase
                end
                OP_NEG, OP_NOT: begin
                    case (r_step)
                        3'd3: begin
                            w_ctrl.grb = 1'b1; w_ctrl.e_rout = 1'b1;
                            w_ctrl.bus = w_bus_rb; w_ctrl.alu_op = alu_code(w_op);
                            w_ctrl.e_z = 1'b1;
                        end
                        3'd4: begin
                            w_ctrl.bus = BUS_ZLO; w_ctrl.gra = 1'b1; w_ctrl.e_rin = 1'b1;
                        end
                        default: ;
                    endcase
                end
                OP_MUL, OP_DIV: begin
                    case (r_step)
                        3'd3: begin
                            w_ctrl.gra = 1'b1; w_ctrl.e_rout = 1'b1;
                            w_ctrl.bus = w_bus_ra; w_ctrl.e_y = 1'b1;
                        end
                        3'd4: begin
                            w_ctrl.grb = 1'b1; w_ctrl.e_rout = 1'b1;
                            w_ctrl.bus = w_bus_rb; w_ctrl.alu_op = alu_code(w_op);
                            w_ctrl.e_z = 1'b1;
                        end
                        3'd5: begin w_ctrl.bus = BUS_ZLO; w_ctrl.e_lo = 1'b1; end
                        3'd6: begin w_ctrl.bus = BUS_ZHI; w_ctrl.e_hi = 1'b1; end
                        default: ;
                    endcase
                end
                OP_LD, OP_LDI, OP_ST: begin
                    case (r_step)
                        3'd3: begin
                            // BAout makes an Rb of R0 read as zero
                            w_ctrl.grb = 1'b1; w_ctrl.e_rout = 1'b1; w_ctrl.ba_out = 1'b1;
                            w_ctrl.bus = w_bus_rb; w_ctrl.e_y = 1'b1;
                        end
                        3'd4: begin
                            w_ctrl.bus = BUS_IMM; w_ctrl.imm_sel = 1'b1;
                            w_ctrl.alu_op = ALU_ADD; w_ctrl.e_z = 1'b1;
                        end
                        3'd5: begin
                            w_ctrl.bus = BUS_ZLO;
                            if (w_op == OP_LDI) begin
                                w_ctrl.gra = 1'b1; w_ctrl.e_rin = 1'b1;
                            end else begin
                                w_ctrl.e_mar = 1'b1;
                            end
                        end
                        3'd6: begin
                            if (w_op == OP_LD) begin
                                w_ctrl.ram_read = 1'b1; w_ctrl.mdr_read = 1'b1;
                                w_ctrl.e_mdr    = 1'b1;
                            end else if (w_op == OP_ST) begin
                                w_ctrl.gra = 1'b1; w_ctrl.e_rout = 1'b1;
                                w_ctrl.bus = w_bus_ra; w_ctrl.ram_write = 1'b1;
                            end
                        end
                        3'd7: begin
                            if (w_op == OP_LD) begin
                                w_ctrl.bus = BUS_MDR; w_ctrl.gra = 1'b1; w_ctrl.e_rin = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
                OP_BR: begin
                    case (r_step)
                        3'd3: begin
                            w_ctrl.gra = 1'b1; w_ctrl.e_rout = 1'b1;
                            w_ctrl.bus = w_bus_ra; w_ctrl.e_ra = 1'b1;
                        end
                        3'd4: w_ctrl.e_con_ff = 1'b1;
                        3'd5: begin w_ctrl.bus = BUS_PC; w_ctrl.e_y = 1'b1; end
                        3'd6: begin
                            w_ctrl.bus = BUS_IMM; w_ctrl.imm_sel = 1'b1;
                            w_ctrl.alu_op = ALU_ADD; w_ctrl.e_z = 1'b1;
                        end
                        3'd7: begin
                            if (CON) begin
                                w_ctrl.bus = BUS_ZLO; w_ctrl.e_pc = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
                OP_JR: begin
                    if (r_step == 3'd3) begin
                        w_ctrl.gra = 1'b1; w_ctrl.e_rout = 1'b1;
                        w_ctrl.bus = w_bus_ra; w_ctrl.e_pc = 1'b1;
                    end
                end
                OP_JAL: begin
                    case (r_step)
                        // e_Rin with no Gr* line steers the write to R15
                        3'd3: begin w_ctrl.bus = BUS_PC; w_ctrl.e_rin = 1'b1; end
                        3'd4: begin
                            w_ctrl.gra = 1'b1; w_ctrl.e_rout = 1'b1;
                            w_ctrl.bus = w_bus_ra; w_ctrl.e_pc = 1'b1;
                        end
                        default: ;
                    endcase
                end
                OP_IN: begin
                    case (r_step)
                        3'd3: w_ctrl.e_inport = 1'b1;
                        3'd4: begin
                            w_ctrl.bus = BUS_INP; w_ctrl.gra = 1'b1; w_ctrl.e_rin = 1'b1;
                        end
                        default: ;
                    endcase
                end
                OP_OUT: begin
                    if (r_step == 3'd3) begin
                        w_ctrl.gra = 1'b1; w_ctrl.e_rout = 1'b1;
                        w_ctrl.bus = w_bus_ra; w_ctrl.e_outport = 1'b1;
                    end
                end
                OP_MFHI, OP_MFLO: begin
                    if (r_step == 3'd3) begin
                        w_ctrl.bus   = (w_op == OP_MFHI) ? BUS_HI : BUS_LO;
                        w_ctrl.gra   = 1'b1;
                        w_ctrl.e_rin = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // clear masks the T0 decode so nothing commits while it is held
    assign w_out = clear ? '0 : w_ctrl;
    assign run   = clear | w_run;

    assign e_PC          = w_out.e_pc;
    assign e_IR          = w_out.e_ir;
    assign e_Y           = w_out.e_y;
    assign e_Z           = w_out.e_z;
    assign e_HI          = w_out.e_hi;
    assign e_LO          = w_out.e_lo;
    assign e_MDR         = w_out.e_mdr;
    assign e_MAR         = w_out.e_mar;
    assign e_OutPort     = w_out.e_outport;
    assign e_InPort      = w_out.e_inport;
    assign e_RA          = w_out.e_ra;
    assign e_CON_FF      = w_out.e_con_ff;
    assign incPC         = w_out.inc_pc;
    assign ram_read      = w_out.ram_read;
    assign ram_write     = w_out.ram_write;
    assign MDR_read      = w_out.mdr_read;
    assign Gra           = w_out.gra;
    assign Grb           = w_out.grb;
    assign Grc           = w_out.grc;
    assign e_Rin         = w_out.e_rin;
    assign e_Rout        = w_out.e_rout;
    assign BAout         = w_out.ba_out;
    assign imm_sel       = w_out.imm_sel;
    assign BusDataSelect = w_out.bus;
    assign ALU_op        = w_out.alu_op;

endmodule
`default_nettype wire

// File: tb/tb_control_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_control_unit
//  Purpose  : Table-driven bench for control_unit. Each record is one clock
//             cycle: IR/CON/stop inputs and the full expected control word.
//             Hand-written sequences cover clear in HALT and mid-instruction.
//  Ports    : none
//  Revision : 1.0 - initial release
// ============================================================================
module tb_control_unit;

    // Expected word: {23 flag bits, bus[4:0], alu[3:0], run}
    localparam logic [22:0] F_PC   = 23'd1 << 22, F_IR   = 23'd1 << 21;
    localparam logic [22:0] F_Y    = 23'd1 << 20, F_Z    = 23'd1 << 19;
    localparam logic [22:0] F_HI   = 23'd1 << 18, F_LO   = 23'd1 << 17;
    localparam logic [22:0] F_MDR  = 23'd1 << 16, F_MAR  = 23'd1 << 15;
    localparam logic [22:0] F_OUTP = 23'd1 << 14, F_INP  = 23'd1 << 13;
    localparam logic [22:0] F_RA   = 23'd1 << 12, F_CON  = 23'd1 << 11;
    localparam logic [22:0] F_INC  = 23'd1 << 10, F_RRD  = 23'd1 << 9;
    localparam logic [22:0] F_RWR  = 23'd1 << 8,  F_MRD  = 23'd1 << 7;
    localparam logic [22:0] F_GRA  = 23'd1 << 6,  F_GRB  = 23'd1 << 5;
    localparam logic [22:0] F_GRC  = 23'd1 << 4,  F_RIN  = 23'd1 << 3;
    localparam logic [22:0] F_ROUT = 23'd1 << 2,  F_BA   = 23'd1 << 1;
    localparam logic [22:0] F_IMM  = 23'd1;

    typedef struct {
        logic [31:0] ir;
        logic        con;
        logic        stp;
        logic [32:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_bad = 0;

    logic        clk = 1'b0, clr = 1'b1, con = 1'b0, stp = 1'b0;
    logic [31:0] ir  = '0;

    logic e_PC, e_IR, e_Y, e_Z, e_HI, e_LO, e_MDR, e_MAR, e_OutPort, e_InPort;
    logic e_RA, e_CON_FF, incPC, ram_read, ram_write, MDR_read;
    logic Gra, Grb, Grc, e_Rin, e_Rout, BAout, imm_sel, run;
    logic [4:0] BusDataSelect;
    logic [3:0] ALU_op;
    logic [32:0] w_act;

    control_unit dut (
        .clock(clk), .clear(clr), .IRout(ir), .CON(con), .stop(stp),
        .e_PC(e_PC), .e_IR(e_IR), .e_Y(e_Y), .e_Z(e_Z), .e_HI(e_HI), .e_LO(e_LO),
        .e_MDR(e_MDR), .e_MAR(e_MAR), .e_OutPort(e_OutPort), .e_InPort(e_InPort),
        .e_RA(e_RA), .e_CON_FF(e_CON_FF), .incPC(incPC),
        .ram_read(ram_read), .ram_write(ram_write), .MDR_read(MDR_read),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .e_Rin(e_Rin), .e_Rout(e_Rout),
        .BAout(BAout), .imm_sel(imm_sel),
        .BusDataSelect(BusDataSelect), .ALU_op(ALU_op), .run(run)
    );

    assign w_act = {e_PC, e_IR, e_Y, e_Z, e_HI, e_LO, e_MDR, e_MAR, e_OutPort,
                    e_InPort, e_RA, e_CON_FF, incPC, ram_read, ram_write, MDR_read,
                    Gra, Grb, Grc, e_Rin, e_Rout, BAout, imm_sel,
                    BusDataSelect, ALU_op, run};

    always #5 clk = ~clk;

    function automatic logic [31:0] mk_ir(input int op, input int ra, input int rb, input int rc);
        return {op[4:0], ra[3:0], rb[3:0], rc[3:0], 15'h0010};
    endfunction

    function automatic logic [32:0] ex(input logic [22:0] f, input int bus, input int alu, input logic r);
        return {f, bus[4:0], alu[3:0], r};
    endfunction

    function automatic vec_t mkv(input logic [31:0] i, input logic c, input logic s, input logic [32:0] e);
        vec_t v;
        v.ir = i; v.con = c; v.stp = s; v.exp = e;
        return v;
    endfunction

    task automatic push(input logic [31:0] i, input logic c, input logic s, input logic [32:0] e);
        vecs.push_back(mkv(i, c, s, e));
    endtask

    task automatic push_t12(input logic [31:0] i, input logic s);
        push(i, 1'b0, s, ex(F_RRD | F_MRD | F_MDR, 0, 0, 1'b1));
        push(i, 1'b0, s, ex(F_IR, 21, 0, 1'b1));
    endtask

    task automatic push_fetch(input logic [31:0] i, input logic c, input logic s);
        push(i, c, 1'b0, ex(F_MAR | F_INC, 20, 0, 1'b1));
        push(i, c, s, ex(F_RRD | F_MRD | F_MDR, 0, 0, 1'b1));
        push(i, c, s, ex(F_IR, 21, 0, 1'b1));
    endtask

    // Drive just after a rising edge, compare on the falling edge
    task automatic apply(input vec_t v, input string tag);
        ir  = v.ir;
        con = v.con;
        stp = v.stp;
        @(negedge clk);
        n_vec++;
        if (w_act !== v.exp) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", tag, w_act, v.exp);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin : main
        logic [31:0] A, S, H;
        logic [32:0] T0, ZERO_RUN, ZERO_STOP;
        T0        = ex(F_MAR | F_INC, 20, 0, 1'b1);
        ZERO_RUN  = ex('0, 0, 0, 1'b1);
        ZERO_STOP = ex('0, 0, 0, 1'b0);

        // stop held at T0, then add R3,R1,R2 with stray stop mid-instruction
        A = mk_ir(3, 3, 1, 2);
        repeat (3) push(A, 1'b0, 1'b1, ZERO_STOP);
        push_fetch(A, 1'b0, 1'b1);
        push(A, 1'b0, 1'b0, ex(F_GRB | F_ROUT | F_Y, 1, 0, 1'b1));
        push(A, 1'b0, 1'b1, ex(F_GRC | F_ROUT | F_Z, 2, 0, 1'b1));
        push(A, 1'b0, 1'b0, ex(F_GRA | F_RIN, 19, 0, 1'b1));
        // shra R6,R7,R8
        S = mk_ir(10, 6, 7, 8);
        push_fetch(S, 1'b0, 1'b0);
        push(S, 1'b0, 1'b0, ex(F_GRB | F_ROUT | F_Y, 7, 0, 1'b1));
        push(S, 1'b0, 1'b0, ex(F_GRC | F_ROUT | F_Z, 8, 7, 1'b1));
        push(S, 1'b0, 1'b0, ex(F_GRA | F_RIN, 19, 0, 1'b1));
        // andi R1,R2,C
        S = mk_ir(13, 1, 2, 0);
        push_fetch(S, 1'b0, 1'b0);
        push(S, 1'b0, 1'b0, ex(F_GRB | F_ROUT | F_Y, 2, 0, 1'b1));
        push(S, 1'b0, 1'b0, ex(F_Z | F_IMM, 23, 2, 1'b1));
        push(S, 1'b0, 1'b0, ex(F_GRA | F_RIN, 19, 0, 1'b1));
        // neg R1,R2
        S = mk_ir(17, 1, 2, 0);
        push_fetch(S, 1'b0, 1'b0);
        push(S, 1'b0, 1'b0, ex(F_GRB | F_ROUT | F_Z, 2, 11, 1'b1));
        push(S, 1'b0, 1'b0, ex(F_GRA | F_RIN, 19, 0, 1'b1));
        // mul R4,R5
        S = mk_ir(16, 4, 5, 0);
        push_fetch(S, 1'b0, 1'b0);
        push(S, 1'b0, 1'b0, ex(F_GRA | F_ROUT | F_Y, 4, 0, 1'b1));
        push(S, 1'b0, 1'b0, ex(F_GRB | F_ROUT | F_Z, 5, 9, 1'b1));
        push(S, 1'b0, 1'b0, ex(F_LO, 19, 0, 1'b1));
        push(S, 1'b0, 1'b0, ex(F_HI, 18, 0, 1'b1));
        // ldi R3,C(R4)
        S = mk_ir(1, 3, 4, 0);
        push_fetch(S, 1'b0, 1'b0);
        push(S, 1'b0, 1'b0, ex(F_GRB | F_ROUT | F_BA | F_Y, 4, 0, 1'b1));
        push(S, 1'b0, 1'b0, ex(F_Z | F_IMM, 23, 0, 1'b1));
        push(S, 1'b0, 1'b0, ex(F_GRA | F_RIN, 19, 0, 1'b1));
        // ld R2,0x10(R0)
        S = mk_ir(0, 2, 0, 0);
        push_fetch(S, 1'b0, 1'b0);
        push(S, 1'b0, 1'b0, ex(F_GRB | F_ROUT | F_BA | F_Y, 0, 0, 1'b1));
        push(S, 1'b0, 1'b0, ex(F_Z | F_IMM, 23, 0, 1'b1));
        push(S, 1'b0, 1'b0, ex(F_MAR, 19, 0, 1'b1));
        push(S, 1'b0, 1'b0, ex(F_RRD | F_MRD | F_MDR, 0, 0, 1'b1));
        push(S, 1'b0, 1'b0, ex(F_GRA | F_RIN, 21, 0, 1'b1));
        // st C(R1),R6
        S = mk_ir(2, 6, 1, 0);
        push_fetch(S, 1'b0, 1'b0);
        push(S, 1'b0, 1'b0, ex(F_GRB | F_ROUT | F_BA | F_Y, 1, 0, 1'b1));
        push(S, 1'b0, 1'b0, ex(F_Z | F_IMM, 23, 0, 1'b1));
        push(S, 1'b0, 1'b0, ex(F_MAR, 19, 0, 1'b1));
        push(S, 1'b0, 1'b0, ex(F_GRA | F_ROUT | F_RWR, 6, 0, 1'b1));
        // br R3,C with CON=0 then CON=1
        S = mk_ir(19, 3, 0, 0);
        for (int k = 0; k < 2; k++) begin
            logic c;
            c = (k == 1);
            push_fetch(S, c, 1'b0);
            push(S, c, 1'b0, ex(F_GRA | F_ROUT | F_RA, 3, 0, 1'b1));
            push(S, c, 1'b0, ex(F_CON, 0, 0, 1'b1));
            push(S, c, 1'b0, ex(F_Y, 20, 0, 1'b1));
            push(S, c, 1'b0, ex(F_Z | F_IMM, 23, 0, 1'b1));
            push(S, c, 1'b0, c ? ex(F_PC, 19, 0, 1'b1) : ZERO_RUN);
        end
        // jr R8
        S = mk_ir(20, 8, 0, 0);
        push_fetch(S, 1'b0, 1'b0);
        push(S, 1'b0, 1'b0, ex(F_GRA | F_ROUT | F_PC, 8, 0, 1'b1));
        // jal R7
        S = mk_ir(21, 7, 0, 0);
        push_fetch(S, 1'b0, 1'b0);
        push(S, 1'b0, 1'b0, ex(F_RIN, 20, 0, 1'b1));
        push(S, 1'b0, 1'b0, ex(F_GRA | F_ROUT | F_PC, 7, 0, 1'b1));
        // in R4 / out R5 / mfhi R9 / mflo R10
        S = mk_ir(22, 4, 0, 0);
        push_fetch(S, 1'b0, 1'b0);
        push(S, 1'b0, 1'b0, ex(F_INP, 0, 0, 1'b1));
        push(S, 1'b0, 1'b0, ex(F_GRA | F_RIN, 22, 0, 1'b1));
        S = mk_ir(23, 5, 0, 0);
        push_fetch(S, 1'b0, 1'b0);
        push(S, 1'b0, 1'b0, ex(F_GRA | F_ROUT | F_OUTP, 5, 0, 1'b1));
        S = mk_ir(24, 9, 0, 0);
        push_fetch(S, 1'b0, 1'b0);
        push(S, 1'b0, 1'b0, ex(F_GRA | F_RIN, 16, 0, 1'b1));
        S = mk_ir(25, 10, 0, 0);
        push_fetch(S, 1'b0, 1'b0);
        push(S, 1'b0, 1'b0, ex(F_GRA | F_RIN, 17, 0, 1'b1));
        // nop, then reserved opcode 30: each is three cycles
        S = mk_ir(26, 0, 0, 0);
        push_fetch(S, 1'b0, 1'b0);
        push(S, 1'b0, 1'b0, T0);
        S = mk_ir(30, 1, 1, 1);
        push_t12(S, 1'b0);
        push(S, 1'b0, 1'b0, T0);
        // halt: quiet T3, then HALT ignores stop
        H = mk_ir(27, 0, 0, 0);
        push_t12(H, 1'b0);
        push(H, 1'b0, 1'b0, ZERO_RUN);
        push(H, 1'b0, 1'b1, ZERO_STOP);
        push(H, 1'b0, 1'b0, ZERO_STOP);
        push(H, 1'b0, 1'b1, ZERO_STOP);

        // reset state: outputs masked, run high
        clr = 1'b1;
        @(posedge clk);
        #1;
        apply(mkv(A, 1'b0, 1'b0, ZERO_RUN), "reset");
        clr = 1'b0;

        foreach (vecs[k]) apply(vecs[k], $sformatf("vec%0d", k));

        // clear leaves HALT
        clr = 1'b1;
        apply(mkv(H, 1'b0, 1'b1, ZERO_RUN), "halt_clear");
        clr = 1'b0;
        apply(mkv(A, 1'b0, 1'b0, T0), "after_halt_t0");
        apply(mkv(A, 1'b0, 1'b0, ex(F_RRD | F_MRD | F_MDR, 0, 0, 1'b1)), "add_t1");
        apply(mkv(A, 1'b0, 1'b0, ex(F_IR, 21, 0, 1'b1)), "add_t2");
        apply(mkv(A, 1'b0, 1'b0, ex(F_GRB | F_ROUT | F_Y, 1, 0, 1'b1)), "add_t3");

        // clear during add T4 abandons it
        clr = 1'b1;
        apply(mkv(A, 1'b0, 1'b0, ZERO_RUN), "clear_mid_add");
        clr = 1'b0;
        apply(mkv(A, 1'b0, 1'b0, T0), "restart_t0");
        apply(mkv(A, 1'b0, 1'b0, ex(F_RRD | F_MRD | F_MDR, 0, 0, 1'b1)), "restart_t1");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
